// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared state encoding, column control bit map and bus sizing
// for the convolutional unit sequencer.
package conv_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;
    localparam int ACC = 0;
    localparam int CLR = 1;
    localparam int LAST = 2;
    // commonControl = {Tc, Tr, kernelStep, neuronStep, convDivIniValue}, MSB first
    function automatic int cc_width(input int depth, input int a);
        return 3 * depth + 2 * a;
    endfunction
    function automatic logic [7:0] col_byte(input logic first, input logic last);
        return 8'(1 << ACC) | (first ? 8'(1 << CLR) : 8'h00) | (last ? 8'(1 << LAST) : 8'h00);
    endfunction
endpackage

// File: rtl/step_addr_gen.sv
// step_addr_gen: A-bit buffer address register that clears, advances by a
// stride modulo 2^A, or holds.
module step_addr_gen #(
    parameter int A = 7
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_add,
    input  logic [A-1:0] i_step,
    output logic [A-1:0] o_addr
);
    logic [A-1:0] r_addr;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_addr <= '0;
        else if (i_clr) r_addr <= '0;
        else if (i_add) r_addr <= r_addr + i_step;
    end
    assign o_addr = r_addr;
endmodule

// File: rtl/conv_unit_sequencer.sv
// conv_unit_sequencer: latches a layer configuration and steps one
// ConvolutionalUnit through taps, pipeline drain and partial-sum hand-off per tile.
module conv_unit_sequencer
    import conv_ctrl_pkg::*;
#(
    parameter int depth = 2,
    parameter int A = 7,
    parameter int PIPE = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic                            i_stall,
    input  logic [depth-1:0]                i_cfg_tr,
    input  logic [depth-1:0]                i_cfg_tc,
    input  logic [A-1:0]                    i_cfg_kernel_step,
    input  logic [A-1:0]                    i_cfg_neuron_step,
    input  logic [depth-1:0]                i_cfg_div_ini,
    input  logic [7:0]                      i_cfg_taps,
    input  logic [7:0]                      i_cfg_tiles,
    output logic [cc_width(depth, A)-1:0]   o_common_control,
    output logic [(1<<depth)-1:0]           o_row_control,
    output logic [8*(1<<depth)-1:0]         o_column_control,
    output logic [A-1:0]                    o_k_addr,
    output logic [A-1:0]                    o_n_addr,
    output logic                            o_buf_read,
    output logic                            o_psum_valid,
    output logic                            o_busy,
    output logic                            o_done
);
    localparam int D = 1 << depth;
    localparam logic [7:0] PIPE_LAST = 8'(PIPE - 1);
    state_t r_state, w_next;
    logic [depth-1:0] r_tr, r_tc, r_div;
    logic [A-1:0] r_kstep, r_nstep;
    logic [7:0] r_last_tap, r_last_tile, r_tap, r_tile, r_pipe;
    logic [D-1:0] r_row, w_row;
    logic [8*D-1:0] r_col, w_col;
    logic r_buf_read, r_psum, r_busy, r_done;
    logic w_load, w_issue, w_first, w_last, w_drain_end;
    logic [7:0] w_byte;
    assign w_load = r_state == S_LOAD;
    assign w_issue = r_state == S_RUN && !i_stall;
    assign w_first = r_tap == 8'd0;
    assign w_last = r_tap == r_last_tap;
    assign w_drain_end = r_state == S_DRAIN && r_pipe == PIPE_LAST;
    assign w_byte = col_byte(w_first, w_last);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_start ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_RUN;
            S_RUN:   w_next = (w_issue && w_last) ? S_DRAIN : S_RUN;
            S_DRAIN: w_next = !w_drain_end ? S_DRAIN : (r_tile == r_last_tile) ? S_DONE : S_RUN;
            default: w_next = S_IDLE;
        endcase
    end
    for (genvar g = 0; g < D; g++) begin : g_lane
        assign w_row[g] = i_cfg_tr >= depth'(g);
        assign w_col[8*g +: 8] = (w_issue && r_tc >= depth'(g)) ? w_byte : 8'h00;
    end
    // Outputs are registered: each reflects the action taken at the preceding edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {r_tr, r_tc, r_div, r_kstep, r_nstep} <= '0;
            {r_last_tap, r_last_tile, r_tap, r_tile, r_pipe} <= '0;
            r_row <= '0;
            r_col <= '0;
            {r_buf_read, r_psum, r_busy, r_done} <= '0;
        end else begin
            r_buf_read <= w_issue;
            r_col <= w_col;
            r_psum <= w_drain_end;
            r_done <= r_state == S_DONE;
            r_busy <= w_next != S_IDLE;
            if (w_load) begin
                r_tr <= i_cfg_tr;
                r_tc <= i_cfg_tc;
                r_div <= i_cfg_div_ini;
                r_kstep <= i_cfg_kernel_step;
                r_nstep <= i_cfg_neuron_step;
                r_last_tap <= (i_cfg_taps == 8'd0) ? 8'd0 : i_cfg_taps - 8'd1;
                r_last_tile <= (i_cfg_tiles == 8'd0) ? 8'd0 : i_cfg_tiles - 8'd1;
                r_row <= w_row;
                r_tap <= 8'd0;
                r_tile <= 8'd0;
                r_pipe <= 8'd0;
            end
            if (w_issue) r_tap <= w_last ? 8'd0 : r_tap + 8'd1;
            if (r_state == S_DRAIN) begin
                r_pipe <= w_drain_end ? 8'd0 : r_pipe + 8'd1;
                if (w_drain_end) r_tile <= r_tile + 8'd1;
            end
        end
    end
    // The kernel address restarts every tile; the neuron address only at LOAD.
    step_addr_gen #(.A(A)) u_kaddr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_load || (w_issue && w_first)),
        .i_add   (w_issue && !w_first),
        .i_step  (r_kstep),
        .o_addr  (o_k_addr)
    );
    step_addr_gen #(.A(A)) u_naddr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_load),
        .i_add   (w_issue && !(w_first && r_tile == 8'd0)),
        .i_step  (r_nstep),
        .o_addr  (o_n_addr)
    );
    assign o_common_control = {r_tc, r_tr, r_kstep, r_nstep, r_div};
    assign o_row_control = r_row;
    assign o_column_control = r_col;
    assign o_buf_read = r_buf_read;
    assign o_psum_valid = r_psum;
    assign o_busy = r_busy;
    assign o_done = r_done;
endmodule

// File: tb/tb_conv_unit_sequencer.sv
// tb_conv_unit_sequencer: scoreboard bench; a timeline model predicts every
// tap, psumValid and done with its cycle, and a monitor checks DUT outputs.
module tb_conv_unit_sequencer;
    localparam int DEPTH = 2;
    localparam int AW = 7;
    localparam int PIPE = 2;
    localparam int D = 1 << DEPTH;
    localparam int CW = 3 * DEPTH + 2 * AW;

    typedef struct {
        int t;
        logic [AW-1:0] k;
        logic [AW-1:0] n;
        logic [8*D-1:0] c;
        logic [D-1:0] r;
    } tap_t;

    logic clk = 0, rst_n = 0, start = 0, stall = 0;
    logic [DEPTH-1:0] cfg_tr = 0, cfg_tc = 0, cfg_div = 0;
    logic [AW-1:0] cfg_ks = 0, cfg_ns = 0;
    logic [7:0] cfg_taps = 0, cfg_tiles = 0;
    logic [CW-1:0] common;
    logic [D-1:0] row;
    logic [8*D-1:0] col;
    logic [AW-1:0] kaddr, naddr;
    logic buf_read, psum, busy, done;

    tap_t q_tap[$];
    int q_psum[$];
    int q_done[$];
    tap_t m_e;
    int m_t;
    logic [CW-1:0] exp_common = '0;
    int total = 0, bad = 0, cyc = 0;
    logic mon_en = 0;

    conv_unit_sequencer #(.depth(DEPTH), .A(AW), .PIPE(PIPE)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stall(stall),
        .i_cfg_tr(cfg_tr), .i_cfg_tc(cfg_tc), .i_cfg_kernel_step(cfg_ks),
        .i_cfg_neuron_step(cfg_ns), .i_cfg_div_ini(cfg_div), .i_cfg_taps(cfg_taps),
        .i_cfg_tiles(cfg_tiles), .o_common_control(common), .o_row_control(row),
        .o_column_control(col), .o_k_addr(kaddr), .o_n_addr(naddr),
        .o_buf_read(buf_read), .o_psum_valid(psum), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL unexpected %s at cycle %0d", name, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (buf_read) begin
                if (q_tap.size() == 0) unexpected("bufRead");
                else begin
                    m_e = q_tap.pop_front();
                    check("tap cycle", 64'(cyc), 64'(m_e.t));
                    check("kAddr", 64'(kaddr), 64'(m_e.k));
                    check("nAddr", 64'(naddr), 64'(m_e.n));
                    check("columnControl", 64'(col), 64'(m_e.c));
                    check("rowControl", 64'(row), 64'(m_e.r));
                end
            end else check("idle columnControl", 64'(col), 64'd0);
            if (psum) begin
                if (q_psum.size() == 0) unexpected("psumValid");
                else begin
                    m_t = q_psum.pop_front();
                    check("psumValid cycle", 64'(cyc), 64'(m_t));
                end
            end
            if (done) begin
                if (q_done.size() == 0) unexpected("done");
                else begin
                    m_t = q_done.pop_front();
                    check("done cycle", 64'(cyc), 64'(m_t));
                    check("commonControl", 64'(common), 64'(exp_common));
                    check("busy at done", 64'(busy), 64'd0);
                end
            end
        end
    end

    // smode: 0 no stall, 1 random stall, 2 stall held for edges s+4..s+6.
    // abort: nonzero -> pull reset at that cycle offset from the start edge.
    task automatic run_layer(input int taps, input int tiles, input int tr, input int tc,
                             input int ks, input int ns, input int dv, input int smode, input int abort);
        int s, t, nt, nl, tmax;
        logic pat [1024];
        tap_t e;
        s = cyc + 1;
        for (int i = 0; i < 1024; i++)
            pat[i] = (smode == 1) ? ($urandom_range(0, 3) == 0) : (smode == 2) ? (i >= 4 && i <= 6) : 1'b0;
        nt = (taps == 0) ? 1 : taps;
        nl = (tiles == 0) ? 1 : tiles;
        t = s + 2;
        for (int j = 0; j < nl; j++) begin
            for (int i = 0; i < nt; i++) begin
                while (pat[t - s]) t++;
                e.t = t;
                e.k = AW'(i * ks);
                e.n = AW'((j * nt + i) * ns);
                for (int c = 0; c < D; c++)
                    e.c[8*c +: 8] = (c <= tc) ? 8'(1 | ((i == 0) ? 2 : 0) | ((i == nt - 1) ? 4 : 0)) : 8'h00;
                e.r = D'((1 << (tr + 1)) - 1);
                q_tap.push_back(e);
                t++;
            end
            t += PIPE - 1;
            q_psum.push_back(t);
            t++;
        end
        q_done.push_back(t);
        tmax = t + 2;
        exp_common = {DEPTH'(tc), DEPTH'(tr), AW'(ks), AW'(ns), DEPTH'(dv)};
        cfg_taps = 8'(taps);
        cfg_tiles = 8'(tiles);
        cfg_tr = DEPTH'(tr);
        cfg_tc = DEPTH'(tc);
        cfg_ks = AW'(ks);
        cfg_ns = AW'(ns);
        cfg_div = DEPTH'(dv);
        start = 1;
        stall = pat[0];
        while (cyc < tmax) begin
            @(negedge clk);
            start = 0;
            if (cyc == s) check("busy in LOAD", 64'(busy), 64'd1);
            if (cyc == s + 1) begin
                cfg_taps = 8'($urandom);
                cfg_tiles = 8'($urandom);
                cfg_tr = DEPTH'($urandom);
                cfg_tc = DEPTH'($urandom);
                cfg_ks = AW'($urandom);
                cfg_ns = AW'($urandom);
                cfg_div = DEPTH'($urandom);
            end
            stall = pat[cyc + 1 - s];
            if (abort != 0 && cyc == s + abort) begin
                rst_n = 0;
                q_tap.delete();
                q_psum.delete();
                q_done.delete();
                #1;
                check("reset kAddr", 64'(kaddr), 64'd0);
                check("reset nAddr", 64'(naddr), 64'd0);
                check("reset commonControl", 64'(common), 64'd0);
                check("reset row/col", 64'({row, col}), 64'd0);
                check("reset flags", 64'({buf_read, psum, busy, done}), 64'd0);
                stall = 0;
                repeat (3) @(negedge clk);
                rst_n = 1;
                return;
            end
        end
        check("pending events", 64'(q_tap.size() + q_psum.size() + q_done.size()), 64'd0);
        stall = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset commonControl", 64'(common), 64'd0);
        check("reset kAddr", 64'(kaddr), 64'd0);
        check("reset nAddr", 64'(naddr), 64'd0);
        check("reset row/col", 64'({row, col}), 64'd0);
        check("reset flags", 64'({buf_read, psum, busy, done}), 64'd0);
        rst_n = 1;
        mon_en = 1;
        @(negedge clk);
        run_layer(3, 1, 1, 2, 2, 1, 1, 0, 0);
        run_layer(6, 1, 3, 3, 5, 7, 2, 2, 0);
        run_layer(2, 2, 0, 1, 1, 3, 0, 0, 0);
        run_layer(3, 1, 2, 0, 100, 1, 3, 0, 0);
        run_layer(0, 0, 3, 3, 9, 9, 1, 0, 0);
        run_layer(3, 1, 1, 1, 4, 4, 0, 0, 5);
        run_layer(2, 1, 2, 2, 3, 5, 1, 0, 0);
        for (int n = 0; n < 8; n++)
            run_layer($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 3), 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_unit_sequencer.md
# conv_unit_sequencer

Sequencer for one ConvolutionalUnit. It latches a per-layer configuration on `start` and drives the unit's `commonControl`, `rowControl` and `columnControl` buses. For each output tile it steps the kernel and neuron buffer read addresses through `cfgTaps` MAC cycles, then signals when the unit's partial sums are valid. It sits between the layer controller (which issues `start`/config) and the ConvolutionalUnit plus its kernel/neuron buffers.

## Interface
- `depth`, 2: log2 of array dimension; `D = 1<<depth` rows/columns
- `A`, 7: local buffer address width (kernelStep/neuronStep width)
- `PIPE`, 2: cycles from last tap issued to partial sums valid at unit output
- `CLK`  in  1  clock, rising edge
- `RESETn`  in  1  asynchronous, active-low reset
- `start`  in  1  begin layer; sampled only in IDLE
- `stall`  in  1  buffers not ready; freezes issue
- `cfgTr`, `cfgTc`  in  depth each  active rows-1 / columns-1
- `cfgKernelStep`, `cfgNeuronStep`  in  A each  address strides
- `cfgDivIni`  in  depth  convDivIniValue
- `cfgTaps`  in  8  MAC cycles per tile (0 treated as 1)
- `cfgTiles`  in  8  tiles per layer (0 treated as 1)
- `commonControl`  out  3*depth+2*A  {Tc,Tr,kernelStep,neuronStep,convDivIniValue}, MSB first
- `rowControl`  out  D  row enable mask
- `columnControl`  out  8*D  per-column control byte, column 0 in bits [7:0]
- `kAddr`, `nAddr`  out  A each  buffer read addresses
- `bufRead`  out  1  buffer read strobe
- `psumValid`  out  1  partial sums valid, 1-cycle pulse per tile
- `busy`  out  1  not in IDLE
- `done`  out  1  1-cycle pulse after last tile

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: `start`=1 -> LOAD.
- LOAD: latch all cfg inputs into registers; zero `kAddr`, `nAddr`, tap counter and tile counter -> RUN.
- RUN: each non-stalled cycle issues one tap:
  - `bufRead`=1.
  - Active columns get byte bit0 = accumulate; bit1 = clear, only on tap 0; bit2 = last, only on final tap. Bits 7:3 are 0.
  - After the tap, `kAddr += kernelStep` and `nAddr += neuronStep`, both mod 2^A.
  - Final tap -> DRAIN.
- DRAIN: counts `PIPE` cycles, then pulses `psumValid`.
  - If more tiles remain: `kAddr` returns to 0, `nAddr` keeps advancing, -> RUN.
  - Otherwise -> DONE.
- DONE: `done`=1 for one cycle -> IDLE.
- Stall (RUN only): counters and addresses hold; `bufRead`=0; all columnControl bytes are 0. DRAIN ignores `stall`.
- Active rows are 0..cfgTr, so `rowControl = (1<<(cfgTr+1))-1`. Active columns are 0..cfgTc. Inactive rows/columns are 0.
- `commonControl` is driven from the latched registers from LOAD onward and holds its value in IDLE.
- `start` while busy is ignored. cfg inputs are don't-care outside LOAD.

## Timing
- Reset values: state IDLE; all outputs 0, including `commonControl`, `kAddr` and `nAddr`.
- All outputs are registered.
- `start` at edge N -> LOAD at N+1 -> first `bufRead` at N+2.
- Unstalled tile: cfgTaps RUN cycles + PIPE DRAIN cycles. `psumValid` is asserted in the last DRAIN cycle.
- Total unstalled latency, start to `done`: 2 + tiles*(taps+PIPE) + 1 cycles.
- `RESETn` low at any time: immediate return to IDLE with reset values. No partial pulse.
- cfgTaps=1: a single tap asserts clear and last together (byte 0x07).

## Structure
- Package `conv_ctrl_pkg` holds:
  - the state enum;
  - columnControl bit indices ACC=0, CLR=1, LAST=2;
  - the commonControl field order/width functions of depth and A.
- Sub-module `step_addr_gen` (A-bit register with clear, step-add and hold enable) is instantiated twice, for kAddr and nAddr.

## Test plan
- Reset, then depth=2, Tr=1, Tc=2, taps=3, tiles=1, steps 2/1 -> required response:
  - rowControl=4'b0011;
  - kAddr 0,2,4; nAddr 0,1,2;
  - column bytes 0x03, 0x01, 0x05 on columns 0-2; column 3 = 0x00;
  - psumValid PIPE cycles after the last tap, then done.
- Stall held 3 cycles mid-RUN -> addresses frozen, bufRead=0, all bytes 0, completion delayed exactly 3 cycles.
- tiles=2, taps=2, neuronStep=3 -> kAddr restarts at 0 for tile 2; nAddr reads 0,3,6,9; two psumValid pulses, one done.
- kernelStep=100, taps=3, A=7 -> kAddr 0,100,72 (wraps mod 128).
- taps=0, tiles=0 -> treated as 1 tap / 1 tile; byte 0x07; done 2+1+PIPE+1 cycles after start.
- RESETn asserted in DRAIN -> all outputs 0 immediately, no psumValid or done. A new start runs normally.
